// File: rtl/pmem_responder_pkg.sv
// Shared types for the physical-memory responder slice.
//   lc3b_pmem_addr  : 16-bit byte address on the cache/pmem line protocol
//   lc3b_cache_line : one 128-bit (16-byte) cache line
//   LINE_OFFSET_W   : byte-offset bits inside a line (ignored by the store)
//   CNT_W           : width of the latency down-counter (LATENCY <= 255)
package pmem_responder_pkg;

  typedef logic [15:0]  lc3b_pmem_addr;
  typedef logic [127:0] lc3b_cache_line;

  localparam int LINE_OFFSET_W = 4;
  localparam int CNT_W         = 8;

endpackage : pmem_responder_pkg

// File: rtl/pmem_line_array.sv
// LINES x 128-bit line store with one synchronous write port and one
// synchronous read port sharing a single index. No reset, so it maps onto
// a block RAM.
//   clk   : clock
//   we    : write enable; din is written to mem[index] on the rising edge
//   index : line index for both the read and the write
//   din   : write line
//   dout  : registered read line, mem[index] as of the previous edge
module pmem_line_array
  import pmem_responder_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] index,
  input  lc3b_cache_line   din,
  output lc3b_cache_line   dout
);

  lc3b_cache_line mem [LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= din;
    end
    dout <= mem[index];
  end

endmodule : pmem_line_array

// File: rtl/pmem_responder.sv
// Memory-side responder for the cache/physical-memory line protocol.
// Accepts one line read or write, waits LATENCY cycles in BUSY, commits
// against the on-chip line store and pulses pmem_resp for one cycle.
//
// Handshake: pmem_read / pmem_write are level requests held by the initiator
// until pmem_resp. A request is accepted on the edge it is seen in IDLE; it
// completes when pmem_resp is high (exactly one cycle, LATENCY+1 cycles after
// acceptance). Dropping the request while BUSY aborts it with no response and
// no side effects. The request still high during RESP is not re-accepted.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   pmem_read     : line read request
//   pmem_write    : line write request (wins if both are high)
//   pmem_address  : byte address; bits [3:0] ignored, upper bits alias
//   pmem_wdata    : write line, sampled at the commit edge
//   pmem_rdata    : registered read line, held until the next read commit
//   pmem_resp     : one-cycle completion pulse
//   busy          : high in BUSY and RESP
//   proto_err     : sticky protocol-violation flag, cleared only by reset
//   dbg_state_o   : FSM state (0 IDLE, 1 BUSY, 2 RESP)
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int LINES   = 64,
  parameter int LATENCY = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pmem_read,
  input  logic           pmem_write,
  input  lc3b_pmem_addr  pmem_address,
  input  lc3b_cache_line pmem_wdata,
  output lc3b_cache_line pmem_rdata,
  output logic           pmem_resp,
  output logic           busy,
  output logic           proto_err,
  output logic [1:0]     dbg_state_o
);

  localparam int               IDX_W    = $clog2(LINES);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             op_wr_q, op_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lc3b_pmem_addr    addr_q, addr_d;
  lc3b_cache_line   rdata_q, rdata_d;
  logic             perr_q, perr_d;

  logic             ram_we;
  logic [IDX_W-1:0] ram_index;
  lc3b_cache_line   ram_dout;
  logic             req_held;

  // The request line that belongs to the latched operation.
  assign req_held = op_wr_q ? pmem_write : pmem_read;

  // In IDLE the array is addressed straight from the bus so the line being
  // accepted is already on dout in the first BUSY cycle; afterwards the
  // latched address keeps it there regardless of bus activity. This is what
  // lets LATENCY=1 commit a read on its single BUSY edge.
  assign ram_index = (state_q == ST_IDLE)
                     ? pmem_address[IDX_W+LINE_OFFSET_W-1:LINE_OFFSET_W]
                     : addr_q[IDX_W+LINE_OFFSET_W-1:LINE_OFFSET_W];

  pmem_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_line_array (
    .clk   (clk),
    .we    (ram_we),
    .index (ram_index),
    .din   (pmem_wdata),
    .dout  (ram_dout)
  );

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    perr_d  = perr_q;
    ram_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pmem_write || pmem_read) begin
          op_wr_d = pmem_write;
          addr_d  = pmem_address;
          cnt_d   = LAT_LOAD;
          state_d = ST_BUSY;
          if (pmem_write && pmem_read) begin
            perr_d = 1'b1;
          end
        end
      end

      ST_BUSY: begin
        if (!req_held) begin
          // Abort: no store update, rdata untouched. An address change on
          // the same edge is part of the initiator walking away, not an error.
          state_d = ST_IDLE;
        end else begin
          if (pmem_address != addr_q) begin
            perr_d = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = ST_RESP;
            if (op_wr_q) begin
              ram_we = 1'b1;
            end else begin
              rdata_d = ram_dout;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_wr_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  assign pmem_rdata  = rdata_q;
  assign pmem_resp   = (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE);
  assign proto_err   = perr_q;
  assign dbg_state_o = state_q;

endmodule : pmem_responder

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;

  localparam int LAT   = 4;
  localparam int LINES = 64;

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] D2 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] D3 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;
  localparam logic [127:0] D4 = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
  localparam logic [127:0] D5 = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
  localparam logic [127:0] D6 = 128'h8765_4321_0FED_CBA9_1357_9BDF_2468_ACE0;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         busy;
  logic         proto_err;
  logic [1:0]   dbg_state;

  int cyc;
  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pmem_responder #(
    .LINES   (LINES),
    .LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .busy         (busy),
    .proto_err    (proto_err),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n        = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one request starting at posedge+1 (cycle 0). Samples on negedges.
  // drop_at / chg_at: cycle at whose start the request is dropped / the
  // address is changed (-1 = never). Returns at posedge+1 after the resp
  // cycle, or after a bounded window when no resp arrives.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [127:0] d, input int drop_at,
                        input int chg_at, input logic [15:0] chg_a,
                        output int resp_at, output int resp_cyc,
                        output logic [127:0] rd_line, output logic [15:0] busy_v);
    resp_at  = -1;
    resp_cyc = -1;
    rd_line  = '0;
    busy_v   = '0;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = a;
    pmem_wdata   = d;
    for (int c = 0; c < LAT + 4 && resp_at < 0; c++) begin
      @(negedge clk);
      busy_v[c] = busy;
      if (pmem_resp) begin
        resp_at  = c;
        resp_cyc = cyc;
        rd_line  = pmem_rdata;
      end
      @(posedge clk);
      #1;
      if (c + 1 == drop_at) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
      if (c + 1 == chg_at) pmem_address = chg_a;
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++; if (pmem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0", pmem_resp); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", proto_err); end
    n_tests++; if (pmem_rdata !== 128'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", pmem_rdata); end
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    int ra, rc;
    logic [127:0] rl;
    logic [15:0] bv;
    do_req(1'b0, 1'b1, 16'h0040, D1, -1, -1, 16'h0, ra, rc, rl, bv);
    n_tests++; if (ra !== 5) begin n_fail++; $display("FAIL wr_resp_cycle: got %0d want 5", ra); end
    n_tests++; if (bv !== 16'h003E) begin n_fail++; $display("FAIL wr_busy_trace: got %h want 003e", bv); end
    do_req(1'b1, 1'b0, 16'h0040, '0, -1, -1, 16'h0, ra, rc, rl, bv);
    n_tests++; if (ra !== 5) begin n_fail++; $display("FAIL rd_resp_cycle: got %0d want 5", ra); end
    n_tests++; if (rl !== D1) begin n_fail++; $display("FAIL rd_data: got %h want %h", rl, D1); end
  endtask

  task automatic test_back_to_back();
    int ra, rc_w, rc_r;
    logic [127:0] rl;
    logic [15:0] bv;
    do_req(1'b0, 1'b1, 16'h0200, D2, -1, -1, 16'h0, ra, rc_w, rl, bv);
    do_req(1'b0, 1'b1, 16'h0100, D3, -1, -1, 16'h0, ra, rc_w, rl, bv);
    n_tests++; if (ra !== 5) begin n_fail++; $display("FAIL b2b_wr_cycle: got %0d want 5", ra); end
    do_req(1'b1, 1'b0, 16'h0200, '0, -1, -1, 16'h0, ra, rc_r, rl, bv);
    n_tests++; if (ra !== 5) begin n_fail++; $display("FAIL b2b_rd_cycle: got %0d want 5", ra); end
    n_tests++; if (rc_r - rc_w !== 6) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 6", rc_r - rc_w); end
    n_tests++; if (rl !== D2) begin n_fail++; $display("FAIL b2b_rd_data: got %h want %h", rl, D2); end
  endtask

  task automatic test_alias();
    int ra, rc;
    logic [127:0] rl;
    logic [15:0] bv;
    do_req(1'b0, 1'b1, 16'h0010, D4, -1, -1, 16'h0, ra, rc, rl, bv);
    do_req(1'b1, 1'b0, 16'h0410, '0, -1, -1, 16'h0, ra, rc, rl, bv);
    n_tests++; if (rl !== D4) begin n_fail++; $display("FAIL alias_rd: got %h want %h", rl, D4); end
    do_req(1'b1, 1'b0, 16'h0040, '0, -1, -1, 16'h0, ra, rc, rl, bv);
    n_tests++; if (rl !== D1) begin n_fail++; $display("FAIL alias_other_line: got %h want %h", rl, D1); end
    n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL alias_perr: got %b want 0", proto_err); end
  endtask

  task automatic test_abort();
    int ra, rc;
    logic [127:0] rl;
    logic [15:0] bv;
    // rdata currently holds D1 from the last read; abort a read of D2's line.
    do_req(1'b1, 1'b0, 16'h0200, '0, 2, -1, 16'h0, ra, rc, rl, bv);
    n_tests++; if (ra !== -1) begin n_fail++; $display("FAIL abort_resp: got cycle %0d want none", ra); end
    n_tests++; if (bv !== 16'h0006) begin n_fail++; $display("FAIL abort_busy_trace: got %h want 0006", bv); end
    n_tests++; if (pmem_rdata !== D1) begin n_fail++; $display("FAIL abort_rdata: got %h want %h", pmem_rdata, D1); end
    do_req(1'b1, 1'b0, 16'h0200, '0, -1, -1, 16'h0, ra, rc, rl, bv);
    n_tests++; if (ra !== 5) begin n_fail++; $display("FAIL post_abort_cycle: got %0d want 5", ra); end
    n_tests++; if (rl !== D2) begin n_fail++; $display("FAIL post_abort_rd: got %h want %h", rl, D2); end
  endtask

  task automatic test_reset_mid_write();
    int ra, rc;
    logic [127:0] rl;
    logic [15:0] bv;
    pmem_write   = 1'b1;
    pmem_address = 16'h0100;
    pmem_wdata   = D5;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_tests++; if (pmem_resp !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp: got %b want 0", pmem_resp); end
    n_tests++; if (pmem_rdata !== 128'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0", pmem_rdata); end
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d want 0", dbg_state); end
    @(posedge clk);
    #1;
    pmem_write = 1'b0;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b1, 1'b0, 16'h0100, '0, -1, -1, 16'h0, ra, rc, rl, bv);
    n_tests++; if (rl !== D3) begin n_fail++; $display("FAIL rstmid_line: got %h want %h", rl, D3); end
  endtask

  task automatic test_addr_change();
    int ra, rc;
    logic [127:0] rl;
    logic [15:0] bv;
    do_req(1'b1, 1'b0, 16'h0040, '0, -1, 2, 16'h0200, ra, rc, rl, bv);
    n_tests++; if (ra !== 5) begin n_fail++; $display("FAIL addrchg_cycle: got %0d want 5", ra); end
    n_tests++; if (rl !== D1) begin n_fail++; $display("FAIL addrchg_rd: got %h want %h", rl, D1); end
    n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL addrchg_perr: got %b want 1", proto_err); end
  endtask

  task automatic test_both_requests();
    int ra, rc;
    logic [127:0] rl;
    logic [15:0] bv;
    n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL both_perr_pre: got %b want 0", proto_err); end
    do_req(1'b1, 1'b1, 16'h0010, D6, -1, -1, 16'h0, ra, rc, rl, bv);
    n_tests++; if (ra !== 5) begin n_fail++; $display("FAIL both_cycle: got %0d want 5", ra); end
    n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL both_perr: got %b want 1", proto_err); end
    do_req(1'b1, 1'b0, 16'h0010, '0, -1, -1, 16'h0, ra, rc, rl, bv);
    n_tests++; if (rl !== D6) begin n_fail++; $display("FAIL both_rd: got %h want %h", rl, D6); end
    n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL both_perr_sticky: got %b want 1", proto_err); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alias();
    test_abort();
    test_reset_mid_write();
    test_addr_change();
    do_reset();
    test_both_requests();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pmem_responder
